// File: rtl/aes_dec.sv
// Iterative AES-128 inverse cipher: one round per enabled cycle, with round keys
// walked backwards from the round-10 key by an inverse key schedule.
package aes_pkg;
   typedef logic [127:0] aes_128;
endpackage

module aes_dec
   import aes_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  logic   start_i,
   input  aes_128 cipher_text_i,
   input  aes_128 key_i,
   output logic   ready_o,
   output aes_128 plain_text_o,
   output logic   done_o
);

   typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} fsm_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 = (a^127)^2; zero maps to zero as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
      return gf_mul(r, r);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] v;
      v = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(v);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   fsm_e        fsm_q, fsm_d;
   aes_128      state_q, state_d;
   aes_128      rkey_q, rkey_d;
   aes_128      pt_q, pt_d;
   logic [3:0]  rnd_q, rnd_d;
   logic        done_q, done_d;

   logic        accept, last_round, round_step;
   logic [31:0] k0, k1, k2, k3;
   logic [31:0] p0, p1, p2, p3;
   logic [31:0] rot_w, sub_word_w;
   aes_128      pk_w, sub_w, t_w, mix_w;

   // Inverse key schedule: recover the previous round key from the current one.
   assign k0    = rkey_q[127:96];
   assign k1    = rkey_q[95:64];
   assign k2    = rkey_q[63:32];
   assign k3    = rkey_q[31:0];
   assign p3    = k3 ^ k2;
   assign p2    = k2 ^ k1;
   assign p1    = k1 ^ k0;
   assign rot_w = {p3[23:0], p3[31:24]};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_key_sub
         assign sub_word_w[31-8*gi -: 8] = sbox(rot_w[31-8*gi -: 8]);
      end
   endgenerate

   assign p0   = k0 ^ sub_word_w ^ {rcon(rnd_q), 24'h0};
   assign pk_w = {p0, p1, p2, p3};

   // InvShiftRows folded into the byte routing: row r rotates right by r columns.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
         assign sub_w[127-8*gi -: 8] = inv_sbox(state_q[127-8*SRC -: 8]);
      end
   endgenerate

   assign t_w = sub_w ^ pk_w;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_inv_mix
         assign mix_w[127-32*gi -: 32] = inv_mix_col(t_w[127-32*gi -: 32]);
      end
   endgenerate

   assign accept     = start_i & ready_o & en;
   assign last_round = (fsm_q == ROUND) & en & (rnd_q == 4'd1);
   assign round_step = (fsm_q == ROUND) & en & (rnd_q != 4'd1);

   always_ff @(posedge clk) begin
      if (rst) fsm_q <= IDLE;
      else     fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (start_i && en) fsm_d = ROUND;
         ROUND:   if (en && rnd_q == 4'd1) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      ready_o = (fsm_q == IDLE);
   end

   always_comb begin
      state_d = state_q;
      rkey_d  = rkey_q;
      rnd_d   = rnd_q;
      pt_d    = pt_q;
      done_d  = 1'b0;
      if (accept) begin
         state_d = cipher_text_i ^ key_i;
         rkey_d  = key_i;
         rnd_d   = 4'd10;
      end else if (last_round) begin
         pt_d   = t_w;
         done_d = 1'b1;
      end else if (round_step) begin
         state_d = mix_w;
         rkey_d  = pk_w;
         rnd_d   = rnd_q - 4'd1;
      end
   end

   // done_q is rewritten every edge, so the pulse is one cycle even with en low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         rkey_q  <= '0;
         pt_q    <= '0;
         rnd_q   <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rkey_q  <= rkey_d;
         pt_q    <= pt_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
      end
   end

   assign plain_text_o = pt_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_aes_dec.sv
// Bench for aes_dec: FIPS-197 vectors, back-to-back, stall, reset and a random
// regression whose ciphertexts come from a software AES encryptor.
module tb_aes_dec;

   logic         clk = 1'b0;
   logic         rst, en, start_i;
   logic [127:0] cipher_text_i, key_i, plain_text_o;
   logic         ready_o, done_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] sbox_t [256];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   always #5 clk = ~clk;

   aes_dec dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .start_i      (start_i),
      .cipher_text_i(cipher_text_i),
      .key_i        (key_i),
      .ready_o      (ready_o),
      .plain_text_o (plain_text_o),
      .done_o       (done_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
      logic [15:0] d;
      d = {v, v} << s;
      return d[15:8];
   endfunction

   function automatic logic [7:0] m2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box from the generator-3 walk: p runs over all non-zero elements while q tracks 1/p.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   task automatic aes_encrypt(input logic [127:0] pt, input logic [127:0] key,
                              output logic [127:0] ct, output logic [127:0] k10);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tmp;
      logic [127:0] rk;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                  ^ {rc, 24'h0};
            rc = m2(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      rk = key;
      for (int r = 1; r <= 10; r++) begin
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[4*c+row] = sbox_t[s[4*((c+row)%4)+row]];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
               s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
            end
         end else begin
            s = t;
         end
         rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      k10 = rk;
   endtask

   // Waits for done_o after start_i has been set up; cycles counts the accept edge as 1.
   task automatic wait_done(input int limit, output int cycles, output logic [127:0] pt);
      cycles = -1;
      pt     = '0;
      for (int n = 1; n <= limit; n++) begin
         tick();
         start_i = 1'b0;
         if (done_o) begin
            cycles = n;
            pt     = plain_text_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; start_i = 1'b0;
      cipher_text_i = '0; key_i = '0;
      tick(); tick();
      rst = 1'b0;
      n_checks++;
      if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
      n_checks++;
      if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
      n_checks++;
      if (plain_text_o !== 128'h0) begin n_fail++; $display("FAIL reset_pt: got %h expected 0", plain_text_o); end
      $display("reset: ready=%b done=%b pt=%h", ready_o, done_o, plain_text_o);
   endtask

   task automatic test_model();
      logic [127:0] ct, k10;
      aes_encrypt(C1_PT, C1_KEY, ct, k10);
      n_checks++;
      if (ct !== C1_CT || k10 !== C1_K10) begin
         n_fail++; $display("FAIL model_c1: got ct=%h k10=%h expected ct=%h k10=%h", ct, k10, C1_CT, C1_K10);
      end
      aes_encrypt(B_PT, B_KEY, ct, k10);
      n_checks++;
      if (ct !== B_CT || k10 !== B_K10) begin
         n_fail++; $display("FAIL model_b: got ct=%h k10=%h expected ct=%h k10=%h", ct, k10, B_CT, B_K10);
      end
   endtask

   task automatic test_c1();
      int           cycles;
      logic [127:0] pt;
      start_i = 1'b1; cipher_text_i = C1_CT; key_i = C1_K10;
      tick();
      start_i = 1'b0;
      n_checks++;
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL c1_busy: ready got %b expected 0", ready_o); end
      wait_done(30, cycles, pt);
      if (cycles > 0) cycles = cycles + 1;
      n_checks++;
      if (cycles != 11) begin n_fail++; $display("FAIL c1_latency: got %0d expected 11", cycles); end
      n_checks++;
      if (pt !== C1_PT) begin n_fail++; $display("FAIL c1_pt: got %h expected %h", pt, C1_PT); end
      n_checks++;
      if (ready_o !== 1'b1) begin n_fail++; $display("FAIL c1_ready_at_done: got %b expected 1", ready_o); end
      tick();
      n_checks++;
      if (done_o !== 1'b0) begin n_fail++; $display("FAIL c1_done_width: got %b expected 0", done_o); end
      n_checks++;
      if (plain_text_o !== C1_PT) begin n_fail++; $display("FAIL c1_pt_hold: got %h expected %h", plain_text_o, C1_PT); end
      $display("c1: latency=%0d pt=%h", cycles, pt);
   endtask

   task automatic test_app_b();
      int           cycles;
      logic [127:0] pt;
      start_i = 1'b1; cipher_text_i = B_CT; key_i = B_K10;
      wait_done(30, cycles, pt);
      n_checks++;
      if (pt !== B_PT || cycles != 11) begin
         n_fail++; $display("FAIL app_b: got pt=%h lat=%0d expected pt=%h lat=11", pt, cycles, B_PT);
      end
      $display("app_b: latency=%0d pt=%h", cycles, pt);
      tick();
   endtask

   task automatic test_back_to_back();
      int           first, second, pulses;
      logic [127:0] pt1, pt2;
      logic         rdy1;
      first = -1; second = -1; pulses = 0; pt1 = '0; pt2 = '0; rdy1 = 1'b0;
      start_i = 1'b1; cipher_text_i = C1_CT; key_i = C1_K10;
      tick();
      cipher_text_i = B_CT; key_i = B_K10;
      for (int n = 2; n <= 40; n++) begin
         tick();
         if (done_o) begin
            pulses++;
            if (first < 0) begin first = n; pt1 = plain_text_o; rdy1 = ready_o; end
            else if (second < 0) begin second = n; pt2 = plain_text_o; end
         end
         if (first > 0 && n >= first + 1)
            start_i = (n > first + 1 && n < first + 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start_i = 1'b0;
      n_checks++;
      if (first != 11 || pt1 !== C1_PT || rdy1 !== 1'b1) begin
         n_fail++; $display("FAIL b2b_first: got at=%0d pt=%h rdy=%b expected at=11 pt=%h rdy=1", first, pt1, rdy1, C1_PT);
      end
      n_checks++;
      if (second - first != 11 || pt2 !== B_PT) begin
         n_fail++; $display("FAIL b2b_second: got gap=%0d pt=%h expected gap=11 pt=%h", second - first, pt2, B_PT);
      end
      n_checks++;
      if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
      $display("b2b: first=%0d second=%0d pulses=%0d", first, second, pulses);
   endtask

   task automatic test_stall();
      logic [31:0]  mask;
      int           first, pulses;
      logic [127:0] pt;
      mask = '0;
      while ($countones(mask) < 3) mask[$urandom_range(2, 10)] = 1'b1;
      first = -1; pulses = 0; pt = '0;
      start_i = 1'b1; cipher_text_i = C1_CT; key_i = C1_K10;
      for (int n = 1; n <= 30; n++) begin
         en = !(mask[n] || n == 15);
         tick();
         start_i = 1'b0;
         if (done_o) begin
            pulses++;
            if (first < 0) begin first = n; pt = plain_text_o; end
         end
      end
      en = 1'b1;
      n_checks++;
      if (first != 14) begin n_fail++; $display("FAIL stall_latency: got %0d expected 14", first); end
      n_checks++;
      if (pt !== C1_PT) begin n_fail++; $display("FAIL stall_pt: got %h expected %h", pt, C1_PT); end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL stall_pulses: got %0d expected 1", pulses); end
      $display("stall: mask=%h done_at=%0d pulses=%0d", mask, first, pulses);
   endtask

   task automatic test_idle_en();
      int pulses;
      pulses = 0;
      en = 1'b0; start_i = 1'b1; cipher_text_i = B_CT; key_i = B_K10;
      for (int n = 0; n < 4; n++) begin tick(); if (done_o) pulses++; end
      n_checks++;
      if (ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_en_ready: got %b expected 1", ready_o); end
      en = 1'b1; start_i = 1'b0;
      for (int n = 0; n < 14; n++) begin tick(); if (done_o) pulses++; end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL idle_en_accept: got %0d pulses expected 0", pulses); end
      $display("idle_en: pulses=%0d", pulses);
   endtask

   task automatic test_reset_mid();
      int           pulses, cycles;
      logic [127:0] pt;
      pulses = 0;
      start_i = 1'b1; cipher_text_i = B_CT; key_i = B_K10;
      tick();
      start_i = 1'b0;
      for (int n = 0; n < 5; n++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (ready_o !== 1'b1 || done_o !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_ctrl: got ready=%b done=%b expected ready=1 done=0", ready_o, done_o);
      end
      n_checks++;
      if (plain_text_o !== 128'h0) begin n_fail++; $display("FAIL rstmid_pt: got %h expected 0", plain_text_o); end
      for (int n = 0; n < 15; n++) begin tick(); if (done_o) pulses++; end
      rst = 1'b1; start_i = 1'b1; cipher_text_i = C1_CT; key_i = C1_K10;
      tick();
      rst = 1'b0; start_i = 1'b0;
      n_checks++;
      if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_vs_accept: ready got %b expected 1", ready_o); end
      for (int n = 0; n < 14; n++) begin tick(); if (done_o) pulses++; end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 0", pulses); end
      start_i = 1'b1;
      wait_done(30, cycles, pt);
      n_checks++;
      if (pt !== C1_PT || cycles != 11) begin
         n_fail++; $display("FAIL rstmid_rerun: got pt=%h lat=%0d expected pt=%h lat=11", pt, cycles, C1_PT);
      end
      $display("reset_mid: pulses=%0d rerun pt=%h", pulses, pt);
      tick();
   endtask

   task automatic test_random(input int count);
      logic [127:0] ptx, key, ct, k10, got;
      int           cycles;
      for (int i = 0; i < count; i++) begin
         ptx = {$urandom, $urandom, $urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         aes_encrypt(ptx, key, ct, k10);
         start_i = 1'b1; cipher_text_i = ct; key_i = k10;
         wait_done(30, cycles, got);
         n_checks++;
         if (got !== ptx) begin
            n_fail++; $display("FAIL random_%0d: got %h expected %h", i, got, ptx);
         end
         $display("rand %0d: ct=%h pt=%h lat=%0d", i, ct, got, cycles);
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_model();
      test_c1();
      test_app_b();
      test_back_to_back();
      test_stall();
      test_idle_en();
      test_reset_mid();
      test_random(1000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
